mio_bus_responder: RTL and testbench

- Bus responder at the far end of the multi-cycle CPU's memory/IO interface.
- Accepts one request at a time on cpu_mio/mem_w/addr/data and decodes it to block RAM, a GPIO pair (switches/LEDs), a 7-segment data register or a free-running counter.
- Returns read data on data_to_cpu and pulses mio_ready to release the CPU from its memory state.

---
 rtl/mio_bus_responder.sv | 128 ++++++++++++
 tb/tb_mio_bus_responder.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: decodes one CPU request at a time to RAM, GPIO,
// 7-seg or counter. Ports: clk/reset, cpu_mio/mem_w/addr_in/data_from_cpu
// request, data_to_cpu/mio_ready response, ram_* RAM port, sw/led/seg_data IO.
module mio_bus_responder #(
  parameter int RAM_AW      = 12,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data_to_cpu,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic [31:0]       seg_data
);

  localparam logic [31:0] SEG_A  = 32'hE000_0000;
  localparam logic [31:0] GPIO_A = 32'hF000_0000;
  localparam logic [31:0] CNT_A  = 32'hF000_0004;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_w;
  logic [2:0]  wcnt;
  logic [31:0] counter;
  logic [31:0] io_rdata;
  logic        ram_hit;
  logic        seg_hit;
  logic        gpio_hit;
  logic        cnt_hit;

  assign ram_hit  = (lat_addr[31:RAM_AW+2] == '0);
  assign seg_hit  = (lat_addr == SEG_A);
  assign gpio_hit = (lat_addr == GPIO_A);
  assign cnt_hit  = (lat_addr == CNT_A);

  // RAM port follows the latched request so it stays stable through WAIT.
  assign ram_addr = lat_addr[RAM_AW+1:2];
  assign ram_din  = lat_data;

  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      seg_hit:  io_rdata = seg_data;
      gpio_hit: io_rdata = {16'h0, sw};
      cnt_hit:  io_rdata = counter;
      default:  io_rdata = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    ram_we    = 1'b0;
    mio_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_mio) state_nx = ACCESS;
      end
      ACCESS: begin
        ram_we   = lat_w & ram_hit & ~reset;
        state_nx = (ram_hit && !lat_w) ? WAIT : RESP;
      end
      WAIT: begin
        if (wcnt == 3'd0) state_nx = RESP;
      end
      RESP: begin
        mio_ready = ~reset;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_w       <= 1'b0;
      wcnt        <= '0;
      data_to_cpu <= '0;
      led         <= '0;
      seg_data    <= '0;
      counter     <= '0;
    end else begin
      state   <= state_nx;
      counter <= counter + 32'd1;
      if (state == IDLE && cpu_mio) begin
        lat_addr <= addr_in;
        lat_data <= data_from_cpu;
        lat_w    <= mem_w;
      end
      if (state == ACCESS) begin
        wcnt <= 3'(RAM_LATENCY - 1);
        if (lat_w) begin
          if (seg_hit)  seg_data <= lat_data;
          if (gpio_hit) led      <= lat_data[15:0];
          // a counter load overrides this cycle's increment
          if (cnt_hit)  counter  <= lat_data;
        end else if (!ram_hit) begin
          data_to_cpu <= io_rdata;
        end
      end
      if (state == WAIT) begin
        if (wcnt == 3'd0) data_to_cpu <= ram_dout;
        else              wcnt <= wcnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: instance a (RAM_LATENCY=1), instance b
// (RAM_LATENCY=3), each with a behavioural RAM, checked against a bus model.
module tb_mio_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_w;
  logic [31:0] addr_in;
  logic [31:0] data_from_cpu;
  logic [15:0] sw;
  logic        cpu_mio_a;
  logic        cpu_mio_b;

  logic [31:0] data_a, data_b;
  logic        rdy_a, rdy_b;
  logic [11:0] ram_addr_a, ram_addr_b;
  logic [31:0] ram_din_a, ram_din_b;
  logic        ram_we_a, ram_we_b;
  logic [31:0] ram_dout_a, ram_dout_b;
  logic [15:0] led_a, led_b;
  logic [31:0] seg_a, seg_b;

  mio_bus_responder #(.RAM_AW(12), .RAM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .cpu_mio(cpu_mio_a), .mem_w(mem_w),
    .addr_in(addr_in), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_a), .mio_ready(rdy_a), .ram_addr(ram_addr_a),
    .ram_din(ram_din_a), .ram_we(ram_we_a), .ram_dout(ram_dout_a),
    .sw(sw), .led(led_a), .seg_data(seg_a)
  );

  mio_bus_responder #(.RAM_AW(12), .RAM_LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .cpu_mio(cpu_mio_b), .mem_w(mem_w),
    .addr_in(addr_in), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_b), .mio_ready(rdy_b), .ram_addr(ram_addr_b),
    .ram_din(ram_din_b), .ram_we(ram_we_b), .ram_dout(ram_dout_b),
    .sw(sw), .led(led_b), .seg_data(seg_b)
  );

  // behavioural RAMs with 1 and 3 cycle read latency
  logic [31:0] ram_a [4096];
  logic [31:0] ram_b [4096];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    if (ram_we_a) ram_a[ram_addr_a] <= ram_din_a;
    pipe_a <= ram_a[ram_addr_a];
    if (ram_we_b) ram_b[ram_addr_b] <= ram_din_b;
    pipe_b[0] <= ram_b[ram_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ram_dout_a = pipe_a;
  assign ram_dout_b = pipe_b[2];

  int cyc = 0;
  int we_cnt_a = 0;
  int rdy_cnt_a = 0;
  int rdy_cnt_b = 0;
  logic [11:0] we_addr_a = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we_a === 1'b1) begin
      we_cnt_a  <= we_cnt_a + 1;
      we_addr_a <= ram_addr_a;
    end
    if (rdy_a === 1'b1) rdy_cnt_a <= rdy_cnt_a + 1;
    if (rdy_b === 1'b1) rdy_cnt_b <= rdy_cnt_b + 1;
  end

  int total = 0;
  int bad = 0;

  // reference model of instance a
  logic [31:0] exp_mem [int];
  logic [15:0] led_m;
  logic [31:0] seg_m;
  logic [31:0] cnt_base;
  int          cnt_cyc;

  function automatic logic [31:0] mem_rd(int i);
    return exp_mem.exists(i) ? exp_mem[i] : 32'h0;
  endfunction

  function automatic logic [31:0] cnt_at(int c);
    return cnt_base + 32'(c - cnt_cyc);
  endfunction

  function automatic bit is_ram(logic [31:0] a);
    return a[31:14] == 18'h0;
  endfunction

  function automatic logic [31:0] exp_read(logic [31:0] a, int acc);
    if (is_ram(a)) return mem_rd(int'(a[13:2]));
    if (a == 32'hE000_0000) return seg_m;
    if (a == 32'hF000_0000) return {16'h0, sw};
    if (a == 32'hF000_0004) return cnt_at(acc);
    return 32'h0;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d, int acc);
    if (is_ram(a)) exp_mem[int'(a[13:2])] = d;
    else if (a == 32'hE000_0000) seg_m = d;
    else if (a == 32'hF000_0000) led_m = d[15:0];
    else if (a == 32'hF000_0004) begin
      cnt_base = d;
      cnt_cyc  = acc + 1;
    end
  endfunction

  function automatic void model_reset();
    led_m    = '0;
    seg_m    = '0;
    cnt_base = '0;
    cnt_cyc  = cyc;
  endfunction

  // One request, issued in an IDLE cycle; returns data and cycles to mio_ready.
  task automatic txn(input bit sel, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit hold,
                     output logic [31:0] rd, output int lat, output int t0);
    t0 = cyc;
    mem_w = w;
    addr_in = a;
    data_from_cpu = d;
    if (sel) cpu_mio_b = 1'b1;
    else     cpu_mio_a = 1'b1;
    lat = 0;
    rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (!hold) begin
          cpu_mio_a = 1'b0;
          cpu_mio_b = 1'b0;
        end
        addr_in = $urandom;
        data_from_cpu = $urandom;
        if (!hold) mem_w = 1'($urandom);
      end
      if ((sel ? rdy_b : rdy_a) === 1'b1) begin
        lat = k;
        rd = sel ? data_b : data_a;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat, t0;
    cpu_mio_a = 0; cpu_mio_b = 0; mem_w = 0;
    addr_in = 0; data_from_cpu = 0; sw = 16'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    total++;
    if ({rdy_a, ram_we_a} !== 2'b00) begin
      bad++; $display("FAIL reset_ctl got=%b exp=00", {rdy_a, ram_we_a});
    end
    total++;
    if (data_a !== 32'h0 || seg_a !== 32'h0 || led_a !== 16'h0) begin
      bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0", data_a, seg_a, led_a);
    end
    total++;
    if (ram_addr_a !== 12'h0 || ram_din_a !== 32'h0) begin
      bad++; $display("FAIL reset_ram got=%h/%h exp=0", ram_addr_a, ram_din_a);
    end
    txn(0, 0, 32'hF000_0004, 0, 0, rd, lat, t0);
    total++;
    if (rd !== exp_read(32'hF000_0004, t0 + 1)) begin
      bad++; $display("FAIL reset_cnt got=%h exp=%h", rd, exp_read(32'hF000_0004, t0 + 1));
    end
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    int lat, t0, wc;
    wc = we_cnt_a;
    txn(0, 1, 32'h10, 32'h1234_5678, 0, rd, lat, t0);
    model_write(32'h10, 32'h1234_5678, t0 + 1);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL ram_wr_lat got=%0d exp=2", lat); end
    total++;
    if (we_cnt_a - wc !== 1 || we_addr_a !== 12'd4) begin
      bad++; $display("FAIL ram_we got=%0d@%h exp=1@004", we_cnt_a - wc, we_addr_a);
    end
    txn(0, 0, 32'h10, 0, 0, rd, lat, t0);
    total++;
    if (rd !== exp_read(32'h10, t0 + 1) || lat !== 3) begin
      bad++; $display("FAIL ram_rd got=%h/%0d exp=%h/3", rd, lat, exp_read(32'h10, t0 + 1));
    end
    txn(0, 0, 32'h13, 0, 0, rd, lat, t0);
    total++;
    if (rd !== exp_read(32'h13, t0 + 1) || lat !== 3) begin
      bad++; $display("FAIL ram_misalign got=%h/%0d exp=%h/3", rd, lat, exp_read(32'h13, t0 + 1));
    end
  endtask

  task automatic test_ram_latency3();
    logic [31:0] rd;
    int lat, t0;
    txn(1, 1, 32'h10, 32'h1234_5678, 0, rd, lat, t0);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL l3_wr_lat got=%0d exp=2", lat); end
    txn(1, 0, 32'h10, 0, 0, rd, lat, t0);
    total++;
    if (rd !== 32'h1234_5678 || lat !== 5) begin
      bad++; $display("FAIL l3_rd got=%h/%0d exp=12345678/5", rd, lat);
    end
  endtask

  task automatic test_gpio();
    logic [31:0] rd;
    int lat, t0;
    sw = 16'hA5A5;
    txn(0, 0, 32'hF000_0000, 0, 0, rd, lat, t0);
    total++;
    if (rd !== exp_read(32'hF000_0000, t0 + 1) || lat !== 2) begin
      bad++; $display("FAIL sw_rd got=%h/%0d exp=%h/2", rd, lat, exp_read(32'hF000_0000, t0 + 1));
    end
    txn(0, 1, 32'hF000_0000, 32'hFFFF_1234, 0, rd, lat, t0);
    model_write(32'hF000_0000, 32'hFFFF_1234, t0 + 1);
    total++;
    if (led_a !== led_m) begin bad++; $display("FAIL led_wr got=%h exp=%h", led_a, led_m); end
    txn(0, 1, 32'hE000_0000, 32'hCAFE_F00D, 0, rd, lat, t0);
    model_write(32'hE000_0000, 32'hCAFE_F00D, t0 + 1);
    txn(0, 0, 32'hE000_0000, 0, 0, rd, lat, t0);
    total++;
    if (rd !== seg_m || seg_a !== seg_m) begin
      bad++; $display("FAIL seg_rw got=%h/%h exp=%h", rd, seg_a, seg_m);
    end
  endtask

  task automatic test_counter();
    logic [31:0] rd;
    int lat, t0;
    txn(0, 1, 32'hF000_0004, 32'hFFFF_FFFE, 0, rd, lat, t0);
    model_write(32'hF000_0004, 32'hFFFF_FFFE, t0 + 1);
    repeat (3) @(posedge clk);
    #1;
    txn(0, 0, 32'hF000_0004, 0, 0, rd, lat, t0);
    total++;
    if (rd !== cnt_at(t0 + 1)) begin
      bad++; $display("FAIL cnt_wrap got=%h exp=%h", rd, cnt_at(t0 + 1));
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    int lat, t0, wc;
    txn(0, 0, 32'h8000_0000, 0, 0, rd, lat, t0);
    total++;
    if (rd !== 32'h0 || lat !== 2) begin
      bad++; $display("FAIL unm_rd got=%h/%0d exp=0/2", rd, lat);
    end
    wc = we_cnt_a;
    txn(0, 1, 32'h8000_0000, 32'hDEAD_BEEF, 0, rd, lat, t0);
    total++;
    if (lat !== 2 || we_cnt_a !== wc || led_a !== led_m || seg_a !== seg_m) begin
      bad++; $display("FAIL unm_wr got=%0d/%0d/%h/%h exp=2/%0d/%h/%h",
                      lat, we_cnt_a, led_a, seg_a, wc, led_m, seg_m);
    end
    txn(0, 0, 32'hF000_0008, 0, 0, rd, lat, t0);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unm_near got=%h exp=0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lat, t0, rc;
    rc = rdy_cnt_a;
    txn(0, 1, 32'hE000_0000, 32'h0BAD_F00D, 1, rd, lat, t0);
    model_write(32'hE000_0000, 32'h0BAD_F00D, t0 + 1);
    total++;
    if (lat !== 2 || rdy_a !== 1'b0) begin
      bad++; $display("FAIL b2b_1 got=%0d/%b exp=2/0", lat, rdy_a);
    end
    txn(0, 0, 32'hE000_0000, 0, 1, rd, lat, t0);
    total++;
    if (rd !== seg_m || lat !== 2 || rdy_a !== 1'b0) begin
      bad++; $display("FAIL b2b_2 got=%h/%0d exp=%h/2", rd, lat, seg_m);
    end
    txn(0, 0, 32'h10, 0, 1, rd, lat, t0);
    cpu_mio_a = 1'b0;
    total++;
    if (rd !== mem_rd(4) || lat !== 3) begin
      bad++; $display("FAIL b2b_3 got=%h/%0d exp=%h/3", rd, lat, mem_rd(4));
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy_cnt_a - rc !== 3) begin
      bad++; $display("FAIL b2b_pulses got=%0d exp=3", rdy_cnt_a - rc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, old, v;
    int lat, t0, wc, rc;
    old = mem_rd(9);
    wc = we_cnt_a;
    rc = rdy_cnt_a;
    mem_w = 1'b1;
    addr_in = 32'h24;
    data_from_cpu = ~old;
    cpu_mio_a = 1'b1;
    @(posedge clk);
    #1;
    cpu_mio_a = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (ram_we_a !== 1'b0) begin bad++; $display("FAIL rst_acc_we got=%b exp=0", ram_we_a); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    total++;
    if (data_a !== 0 || led_a !== 0 || seg_a !== 0 || ram_addr_a !== 0 || ram_din_a !== 0) begin
      bad++; $display("FAIL rst_acc_out got=%h/%h/%h/%h/%h exp=0",
                      data_a, led_a, seg_a, ram_addr_a, ram_din_a);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (we_cnt_a !== wc || rdy_cnt_a !== rc) begin
      bad++; $display("FAIL rst_acc_quiet got=%0d/%0d exp=%0d/%0d", we_cnt_a, rdy_cnt_a, wc, rc);
    end
    txn(0, 0, 32'h24, 0, 0, rd, lat, t0);
    total++;
    if (rd !== old || lat !== 3) begin
      bad++; $display("FAIL rst_acc_after got=%h/%0d exp=%h/3", rd, lat, old);
    end
    v = $urandom;
    txn(1, 1, 32'h40, v, 0, rd, lat, t0);
    rc = rdy_cnt_b;
    mem_w = 1'b0;
    addr_in = 32'h40;
    cpu_mio_b = 1'b1;
    @(posedge clk);
    #1;
    cpu_mio_b = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (rdy_cnt_b !== rc || data_b !== 32'h0) begin
      bad++; $display("FAIL rst_wait got=%0d/%h exp=%0d/0", rdy_cnt_b, data_b, rc);
    end
    txn(1, 0, 32'h40, 0, 0, rd, lat, t0);
    total++;
    if (rd !== v || lat !== 5) begin
      bad++; $display("FAIL rst_wait_after got=%h/%0d exp=%h/5", rd, lat, v);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, e;
    int lat, t0, el;
    bit w;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 63));
        2: a = 32'hE000_0000;
        3: a = 32'hF000_0000;
        4: a = 32'hF000_0004;
        default: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
      w = 1'($urandom);
      d = $urandom;
      sw = 16'($urandom);
      txn(0, w, a, d, 0, rd, lat, t0);
      el = (!w && is_ram(a)) ? 3 : 2;
      if (w) begin
        model_write(a, d, t0 + 1);
        total++;
        if (lat !== el) begin
          bad++; $display("FAIL rnd_wr a=%h lat=%0d exp=%0d", a, lat, el);
        end
      end else begin
        e = exp_read(a, t0 + 1);
        total++;
        if (rd !== e || lat !== el) begin
          bad++; $display("FAIL rnd_rd a=%h got=%h/%0d exp=%h/%0d", a, rd, lat, e, el);
        end
      end
    end
    total++;
    if (led_a !== led_m || seg_a !== seg_m) begin
      bad++; $display("FAIL rnd_io got=%h/%h exp=%h/%h", led_a, seg_a, led_m, seg_m);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    for (int i = 0; i < 3; i++) pipe_b[i] = '0;
    pipe_a = '0;
    test_reset();
    test_ram();
    test_ram_latency3();
    test_gpio();
    test_counter();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
